// File: rtl/full_adder_if.sv
// full_adder_if: operand/result bundle for full_adder; the master drives operands, the slave returns results
interface full_adder_if #(parameter int WIDTH = 1);
  logic             in_valid;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             c_in;
  logic             out_valid;
  logic             c_out;
  logic [WIDTH-1:0] sum;
  logic             ovf;
  modport master (output in_valid, in1, in2, c_in, input out_valid, c_out, sum, ovf);
  modport slave  (input in_valid, in1, in2, c_in, output out_valid, c_out, sum, ovf);
endinterface

// File: rtl/full_adder.sv
// full_adder: WIDTH-bit ripple-carry adder with 1-cycle registered outputs; defining FULL_ADDER_COMB_EN makes it purely combinational
module full_adder #(
  parameter int WIDTH = 1
) (
  input logic         clk,
  input logic         rst_n,
  full_adder_if.slave bus
);
  logic [WIDTH-1:0] a, b, s;
  logic [WIDTH:0]   c;
  logic             ovf_w;
  assign a    = bus.in1;
  assign b    = bus.in2;
  assign c[0] = bus.c_in;
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign ovf_w = c[WIDTH] ^ c[WIDTH-1];
`ifdef FULL_ADDER_COMB_EN
  logic unused_clk_rst;
  assign unused_clk_rst = clk & rst_n;
  assign bus.out_valid  = bus.in_valid;
  assign bus.c_out      = c[WIDTH];
  assign bus.sum        = s;
  assign bus.ovf        = ovf_w;
`else
  logic             valid_q, valid_d;
  logic             c_out_q, c_out_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;
  // results only load on valid so X on idle operands never reaches the outputs
  always_comb begin
    valid_d = bus.in_valid;
    c_out_d = bus.in_valid ? c[WIDTH] : c_out_q;
    sum_d   = bus.in_valid ? s : sum_q;
    ovf_d   = bus.in_valid ? ovf_w : ovf_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      c_out_q <= 1'b0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      c_out_q <= c_out_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end
  assign bus.out_valid = valid_q;
  assign bus.c_out     = c_out_q;
  assign bus.sum       = sum_q;
  assign bus.ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: checks full_adder at WIDTH 1, 8 and 16 against an arithmetic reference model
module tb_full_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  always #5 clk = ~clk;
  full_adder_if #(.WIDTH(1))  if1 ();
  full_adder_if #(.WIDTH(8))  if8 ();
  full_adder_if #(.WIDTH(16)) if16 ();
  full_adder #(.WIDTH(1))  u1  (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  full_adder #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  full_adder #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic longint sext(input int w, input longint unsigned v);
    return v[w-1] ? longint'(v) - (longint'(1) << w) : longint'(v);
  endfunction
  function automatic bit ref_ovf(input int w, input longint unsigned x, input longint unsigned y, input bit ci);
    longint r;
    r = sext(w, x) + sext(w, y) + longint'(ci);
    return r > ((longint'(1) << (w - 1)) - 1) || r < -(longint'(1) << (w - 1));
  endfunction
  task automatic drive16(input bit v, input logic [15:0] x, input logic [15:0] y, input logic ci);
    if16.in_valid = v;
    if16.in1 = x;
    if16.in2 = y;
    if16.c_in = ci;
  endtask
  initial begin
    if1.in_valid = 1'b0;
    if8.in_valid = 1'b0;
    if16.in_valid = 1'b0;
    {if1.in1, if1.in2, if1.c_in} = 'x;
    {if8.in1, if8.in2, if8.c_in} = 'x;
    {if16.in1, if16.in2, if16.c_in} = 'x;
`ifdef FULL_ADDER_COMB_EN
    #1;
    if1.in_valid = 1'b1;
    if1.in1 = 1'b1;
    if1.in2 = 1'b0;
    if1.c_in = 1'b1;
    #1;
    chk("comb_valid", if1.out_valid, 1);
    chk("comb_c_out", if1.c_out, 1);
    chk("comb_sum", if1.sum, 0);
    for (int i = 0; i < 50; i++) begin
      logic [15:0] x, y;
      logic ci;
      logic [16:0] t;
      x = 16'($urandom);
      y = 16'($urandom);
      ci = 1'($urandom);
      drive16(1'b1, x, y, ci);
      #1;
      t = 17'(x) + 17'(y) + 17'(ci);
      chk("comb_rand", {if16.c_out, if16.sum}, t);
      chk("comb_rand_ovf", if16.ovf, ref_ovf(16, x, y, ci));
    end
`else
    tick();
    chk("rst_valid", if16.out_valid, 0);
    chk("rst_sum", if16.sum, 0);
    chk("rst_cout", if16.c_out, 0);
    chk("rst_ovf", if16.ovf, 0);
    chk("rst_idle_w1", {if1.out_valid, if1.c_out, if1.sum, if1.ovf}, 0);
    chk("rst_idle_w8", {if8.out_valid, if8.c_out, if8.sum, if8.ovf}, 0);
    drive16(1'b1, 16'd1, 16'd1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_hold_valid", if16.out_valid, 0);
      chk("rst_hold_sum", if16.sum, 0);
      chk("rst_hold_cout", if16.c_out, 0);
    end
    rst_n = 1'b1;
    tick();
    chk("release_valid", if16.out_valid, 1);
    chk("release_sum", if16.sum, 2);
    for (int k = 0; k < 8; k++) begin
      logic [2:0] kv;
      kv = 3'(k);
      if1.in_valid = 1'b1;
      if1.in1 = kv[2];
      if1.in2 = kv[1];
      if1.c_in = kv[0];
      tick();
      chk("w1_valid", if1.out_valid, 1);
      chk("w1_truth", {if1.c_out, if1.sum}, 2'(kv[2]) + 2'(kv[1]) + 2'(kv[0]));
    end
    if1.in_valid = 1'b0;
    if8.in_valid = 1'b1;
    if8.in1 = 8'hFF;
    if8.in2 = 8'h00;
    if8.c_in = 1'b1;
    tick();
    chk("w8_wrap", {if8.ovf, if8.c_out, if8.sum}, {1'b0, 1'b1, 8'h00});
    if8.in1 = 8'h7F;
    if8.in2 = 8'h01;
    if8.c_in = 1'b0;
    tick();
    chk("w8_ovf", {if8.ovf, if8.c_out, if8.sum}, {1'b1, 1'b0, 8'h80});
    if8.in_valid = 1'b0;
    drive16(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    tick();
    chk("ones_sum", if16.sum, 16'hFFFF);
    chk("ones_cout", if16.c_out, 1);
    drive16(1'b1, 16'h0000, 16'h0000, 1'b0);
    tick();
    chk("zero_all", {if16.ovf, if16.c_out, if16.sum}, 0);
    drive16(1'b1, 16'd5, 16'd6, 1'b0);
    tick();
    drive16(1'b0, 'x, 'x, 'x);
    tick();
    chk("hold_valid", if16.out_valid, 0);
    chk("hold_sum", if16.sum, 11);
    chk("hold_cout_ovf", {if16.c_out, if16.ovf}, 0);
    drive16(1'b1, 16'h8000, 16'h8000, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst", {if16.out_valid, if16.c_out, if16.sum, if16.ovf}, 0);
    rst_n = 1'b1;
    drive16(1'b0, 'x, 'x, 'x);
    tick();
    chk("post_rst_valid", if16.out_valid, 0);
    chk("post_rst_sum", if16.sum, 0);
    begin
      logic            ev, ec, eo;
      logic [15:0]     es;
      logic [16:0]     t;
      logic [15:0]     x, y;
      logic            ci, v;
      ev = 1'b0; ec = 1'b0; eo = 1'b0; es = '0;
      for (int i = 0; i < 10000; i++) begin
        v = ($urandom_range(3) != 0);
        x = 16'($urandom);
        y = 16'($urandom);
        ci = 1'($urandom);
        drive16(v, x, y, ci);
        tick();
        ev = v;
        if (v) begin
          t = 17'(x) + 17'(y) + 17'(ci);
          {ec, es} = t;
          eo = ref_ovf(16, x, y, ci);
        end
        chk("rand_valid", if16.out_valid, ev);
        chk("rand_sum", {if16.c_out, if16.sum}, {ec, es});
        chk("rand_ovf", if16.ovf, eo);
      end
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 Parameter WIDTH, default 1: operand width in bits; legal range 1..64.
REQ-002 clk  input  1  rising-edge clock for all sequential logic.
REQ-003 rst_n  input  1  reset, synchronous and active-low, sampled on the rising edge of clk.
REQ-004 in_valid  input  1  qualifies in1, in2 and c_in in the current cycle.
REQ-005 in1  input  WIDTH  addend A, unsigned.
REQ-006 in2  input  WIDTH  addend B, unsigned.
REQ-007 c_in  input  1  carry into bit 0.
REQ-008 out_valid  output  1  qualifies c_out, sum and ovf.
REQ-009 c_out  output  1  carry out of bit WIDTH-1.
REQ-010 sum  output  WIDTH  low WIDTH bits of in1+in2+c_in.
REQ-011 ovf  output  1  signed overflow: carry into the MSB XOR carry out of the MSB.

Function
REQ-012 {c_out,sum} SHALL equal in1+in2+c_in, computed exactly in WIDTH+1 bits with no truncation beyond WIDTH+1.
REQ-013 The adder SHALL be a ripple chain of WIDTH one-bit full-adder cells: s=a^b^ci, co=(a&b)|(ci&(a^b)).
REQ-014 For WIDTH=1, the outputs SHALL match the full-adder truth table for all 8 input combinations, e.g. 1,1,1 -> c_out=1, sum=1.
REQ-015 Registered mode (default): on each rising clk edge with rst_n=1, out_valid SHALL load in_valid.
REQ-016 In registered mode, c_out, sum and ovf SHALL load only when in_valid=1 and SHALL hold their previous values when in_valid=0.
REQ-017 Latency in registered mode SHALL be exactly 1 cycle, with throughput of one operation per cycle and no stall or backpressure.
REQ-018 All-ones operands with c_in=1 SHALL give sum = all ones and c_out=1 (wrap-around boundary).
REQ-019 All-zero operands with c_in=0 SHALL give sum=0, c_out=0, ovf=0.
REQ-020 X or Z on the data inputs while in_valid=0 SHALL NOT propagate to the outputs.

Reset
REQ-021 When rst_n=0 at a rising clk edge, out_valid, c_out, sum and ovf SHALL all become 0, regardless of in_valid.
REQ-022 Reset SHALL take priority over a simultaneous in_valid=1; that operation is discarded.
REQ-023 Reset asserted mid-stream SHALL drop any in-flight result, and out_valid SHALL be 0 in the cycle after reset is released unless in_valid=1 on the release edge.
REQ-024 No output SHALL change asynchronously on rst_n.

Configuration
REQ-025 Macro FULL_ADDER_COMB_EN, when defined, SHALL make the outputs purely combinational:
- out_valid=in_valid, and c_out, sum and ovf follow the inputs with zero latency.
- clk and rst_n are unused in this mode.
REQ-026 When FULL_ADDER_COMB_EN is not defined, the registered behaviour of REQ-015..REQ-024 SHALL apply.

Verification
REQ-027 WIDTH=1, registered mode: apply all 8 combinations of in1/in2/c_in with in_valid=1 -> one cycle later, {c_out,sum} = 00,01,01,10,01,10,10,11 in order.
REQ-028 WIDTH=8: in1=0xFF, in2=0x00, c_in=1 -> sum=0x00, c_out=1, ovf=0; in1=0x7F, in2=0x01, c_in=0 -> sum=0x80, ovf=1.
REQ-029 Hold rst_n=0 for 2 cycles with in_valid=1 and in1=in2=1 -> out_valid=0, sum=0, c_out=0 throughout; first result appears 1 cycle after release.
REQ-030 in_valid=1 with a result, then in_valid=0 with new operands -> out_valid drops to 0, and sum/c_out hold the prior result.
REQ-031 FULL_ADDER_COMB_EN defined, WIDTH=1: in1=1, in2=0, c_in=1 -> c_out=1, sum=0 within the same timestep with no clock edge.
REQ-032 Random 10k vectors at WIDTH=16 -> {c_out,sum} matches the reference sum in1+in2+c_in.
